// File: rtl/fpu_pkg.sv
// Shared FPU definitions: reduction FSM states, element-width helper,
// canonical quiet-NaN pattern and NaN classification for sign-magnitude
// floating-point formats of arbitrary exponent/mantissa width (up to 64 bits).
package fpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Element width: sign + exponent + mantissa.
   function automatic int calc_w(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

   // Canonical qNaN: positive sign, all-ones exponent, mantissa MSB set.
   function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < 64; i++) begin
         if (i >= man_w && i < man_w + exp_w) v[i] = 1'b1;
      end
      v[man_w-1] = 1'b1;
      return v;
   endfunction

   // NaN: exponent all ones and a non-zero mantissa.
   function automatic logic is_nan(input logic [63:0] val, input int exp_w, input int man_w);
      logic exp_ones;
      logic man_nz;
      exp_ones = 1'b1;
      man_nz   = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (i < man_w) man_nz = man_nz | val[i];
         else if (i < man_w + exp_w) exp_ones = exp_ones & val[i];
      end
      return exp_ones & man_nz;
   endfunction

endpackage

// File: rtl/fminmax_cmp.sv
// Combinational sign-magnitude compare: sel_b says whether candidate b should
// replace the running value a under the current min/max mode. Ties keep a.
// With FMINMAX_NAN_EN a NaN never wins against a number and a number always
// wins against a NaN.
module fminmax_cmp
   import fpu_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic                 mode_max,
   output logic                 sel_b
);

   localparam int W = calc_w(EXP_W, MAN_W);

   logic             sa, sb;
   logic [W-2:0]     ma, mb;
   logic             b_lt_a, b_gt_a, order_sel;

   assign sa = a[W-1];
   assign sb = b[W-1];
   assign ma = a[W-2:0];
   assign mb = b[W-2:0];

   // Strict ordering; differing signs also covers -0 < +0.
   always_comb begin
      b_lt_a = 1'b0;
      b_gt_a = 1'b0;
      if (sa != sb) begin
         b_lt_a = sb;
         b_gt_a = sa;
      end else if (!sa) begin
         b_lt_a = (mb < ma);
         b_gt_a = (mb > ma);
      end else begin
         b_lt_a = (mb > ma);
         b_gt_a = (mb < ma);
      end
      order_sel = mode_max ? b_gt_a : b_lt_a;
   end

`ifdef FMINMAX_NAN_EN
   logic a_nan, b_nan;
   assign a_nan = is_nan(64'(a), EXP_W, MAN_W);
   assign b_nan = is_nan(64'(b), EXP_W, MAN_W);

   // minNum/maxNum: numbers dominate NaNs regardless of ordering.
   always_comb begin
      sel_b = order_sel;
      if (b_nan)      sel_b = 1'b0;
      else if (a_nan) sel_b = 1'b1;
   end
`else
   assign sel_b = order_sel;
`endif

endmodule

// File: rtl/fminmax_reduce.sv
// Streaming min/max reduction over valid/ready packets. Emits one registered
// result per packet with a saturating beat count.
// Optional macro FMINMAX_NAN_EN: IEEE minNum/maxNum NaN handling and out_nan.
//
// state    | meaning
// ST_IDLE  | accumulator empty, waiting for first beat of a packet
// ST_ACCUM | packet in progress, folding beats into accumulator
// ST_DONE  | result presented, input stalled until out_ready
module fminmax_reduce
   import fpu_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode_max_i,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] out_data,
   output logic [CNT_W-1:0]     out_count,
   output logic                 out_nan
);

   localparam int W = calc_w(EXP_W, MAN_W);

   state_e           state_q, state_d;
   logic [W-1:0]     acc_q, acc_d;
   logic             mode_q, mode_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [W-1:0]     load_val;
   logic             sel_b;
   logic             accept;

   fminmax_cmp #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_cmp (
      .a        (acc_q),
      .b        (in_data),
      .mode_max (mode_q),
      .sel_b    (sel_b)
   );

`ifdef FMINMAX_NAN_EN
   localparam logic [63:0]  QNAN_FULL = qnan_bits(EXP_W, MAN_W);
   localparam logic [W-1:0] QNAN      = QNAN_FULL[W-1:0];

   logic in_nan;
   logic nan_q, nan_d;

   // NaNs are canonicalised on load so an all-NaN packet ends as the qNaN.
   assign in_nan   = is_nan(64'(in_data), EXP_W, MAN_W);
   assign load_val = in_nan ? QNAN : in_data;

   // Sticky per-packet NaN flag.
   always_comb begin
      nan_d = nan_q;
      if (accept) nan_d = (state_q == ST_IDLE) ? in_nan : (nan_q | in_nan);
   end

   // NaN flag register; cleared on reset so an aborted packet leaves no trace.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) nan_q <= 1'b0;
      else        nan_q <= nan_d;
   end

   assign out_nan = nan_q;
`else
   assign load_val = in_data;
   assign out_nan  = 1'b0;
`endif

   assign accept = in_valid & in_ready;

   // Next-state, accumulator and handshake logic.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mode_d    = mode_q;
      count_d   = count_q;
      in_ready  = 1'b1;
      out_valid = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               acc_d   = load_val;
               mode_d  = mode_max_i;
               count_d = CNT_W'(1);
               state_d = in_last ? ST_DONE : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (accept) begin
               if (sel_b) acc_d = load_val;
               if (count_q != '1) count_d = count_q + 1'b1;
               if (in_last) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; acc/count double as the held outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         mode_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mode_q  <= mode_d;
         count_q <= count_d;
      end
   end

   assign out_data  = acc_q;
   assign out_count = count_q;

endmodule
